// File: rtl/sysctrl_hkspi_if.sv
// Serial pins of the housekeeping SPI port: the host drives csb/sck/sdi,
// and the slave returns sdo/sdo_oe.
interface sysctrl_hkspi_if;
    logic csb;
    logic sck;
    logic sdi;
    logic sdo;
    logic sdo_oe;

    modport master (output csb, sck, sdi, input sdo, sdo_oe);
    modport slave  (input csb, sck, sdi, output sdo, sdo_oe);
endinterface

// File: rtl/sysctrl_hkspi.sv
// Housekeeping SPI slave (mode 0, oversampled by clock) with chip ID and PLL control registers.
// Define HKSPI_IRQ_EN to add the irq output and its read/write register at 0x0A.
module sysctrl_hkspi #(
    parameter logic [11:0] MFG_ID   = 12'h456,
    parameter logic [7:0]  PROD_ID  = 8'h10,
    parameter logic [31:0] MASK_REV = 32'h0
) (
    input  logic              clock,
    input  logic              reset,
    sysctrl_hkspi_if.slave    spi,
`ifdef HKSPI_IRQ_EN
    output logic              irq,
`endif
    output logic              pll_ena,
    output logic              pll_dco_ena,
    output logic              pll_bypass,
    output logic [25:0]       pll_trim,
    output logic [2:0]        pll_sel,
    output logic [2:0]        pll90_sel,
    output logic [4:0]        pll_div
);

    typedef enum logic [2:0] {IDLE, COMMAND, ADDRESS, DATA, IGNORE} state_t;

    state_t      state, next_state;
    logic [1:0]  csb_sync, sdi_sync;
    logic [2:0]  sck_sync;
    logic        csb_s, sdi_s, sck_rise, sck_fall;
    logic [2:0]  bit_cnt;
    logic [6:0]  shift_in;
    logic [7:0]  byte_val, addr, read_addr, read_data, rd_shift;
    logic        wr_mode, rd_mode, byte_done, load_read, write_strobe;
    logic        sdo_q, sdo_oe_c;

    // csb idles high, so its synchroniser resets high to avoid a false frame start
    always_ff @(posedge clock) begin
        if (reset) begin
            csb_sync <= 2'b11;
            sck_sync <= 3'b000;
            sdi_sync <= 2'b00;
        end else begin
            csb_sync <= {csb_sync[0], spi.csb};
            sck_sync <= {sck_sync[1:0], spi.sck};
            sdi_sync <= {sdi_sync[0], spi.sdi};
        end
    end

    assign csb_s    = csb_sync[1];
    assign sdi_s    = sdi_sync[1];
    assign sck_rise = sck_sync[1] & ~sck_sync[2];
    assign sck_fall = ~sck_sync[1] & sck_sync[2];

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state   = state;
        byte_val     = {shift_in, sdi_s};
        byte_done    = 1'b0;
        load_read    = 1'b0;
        write_strobe = 1'b0;
        read_addr    = addr + 8'd1;
        sdo_oe_c     = 1'b0;
        if (csb_s) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE:    next_state = COMMAND;
                COMMAND: if (sck_rise && bit_cnt == 3'd7) begin
                    byte_done = 1'b1;
                    if (byte_val == 8'h80 || byte_val == 8'h40 || byte_val == 8'hC0)
                        next_state = ADDRESS;
                    else
                        next_state = IGNORE;
                end
                ADDRESS: if (sck_rise && bit_cnt == 3'd7) begin
                    byte_done  = 1'b1;
                    load_read  = 1'b1;
                    read_addr  = byte_val;
                    next_state = DATA;
                end
                DATA: begin
                    sdo_oe_c = rd_mode;
                    if (sck_rise && bit_cnt == 3'd7) begin
                        byte_done    = 1'b1;
                        load_read    = 1'b1;
                        write_strobe = wr_mode;
                    end
                end
                IGNORE:  next_state = IGNORE;
                default: next_state = IDLE;
            endcase
        end
    end

    // The next byte's read data is fetched before this byte's write lands,
    // which gives read/write mode its read-before-write behaviour
    always_ff @(posedge clock) begin
        if (reset) begin
            bit_cnt  <= 3'd0;
            shift_in <= 7'd0;
            addr     <= 8'd0;
            wr_mode  <= 1'b0;
            rd_mode  <= 1'b0;
            rd_shift <= 8'd0;
            sdo_q    <= 1'b0;
        end else if (csb_s) begin
            bit_cnt <= 3'd0;
            sdo_q   <= 1'b0;
        end else begin
            if (sck_rise && state != IDLE) begin
                bit_cnt  <= bit_cnt + 3'd1;
                shift_in <= byte_val[6:0];
            end
            if (byte_done && state == COMMAND) begin
                wr_mode <= byte_val[7];
                rd_mode <= byte_val[6];
            end
            if (byte_done && state == ADDRESS) addr <= byte_val;
            if (byte_done && state == DATA)    addr <= addr + 8'd1;
            if (load_read) begin
                rd_shift <= read_data;
            end else if (sck_fall && state == DATA && rd_mode) begin
                sdo_q    <= rd_shift[7];
                rd_shift <= {rd_shift[6:0], 1'b0};
            end
        end
    end

    assign spi.sdo    = sdo_q;
    assign spi.sdo_oe = sdo_oe_c;

    always_comb begin
        read_data = 8'h00;
        case (read_addr)
            8'h01:   read_data = {4'b0, MFG_ID[11:8]};
            8'h02:   read_data = MFG_ID[7:0];
            8'h03:   read_data = PROD_ID;
            8'h04:   read_data = MASK_REV[31:24];
            8'h05:   read_data = MASK_REV[23:16];
            8'h06:   read_data = MASK_REV[15:8];
            8'h07:   read_data = MASK_REV[7:0];
            8'h08:   read_data = {6'b0, pll_dco_ena, pll_ena};
            8'h09:   read_data = {7'b0, pll_bypass};
`ifdef HKSPI_IRQ_EN
            8'h0A:   read_data = {7'b0, irq};
`endif
            8'h0D:   read_data = pll_trim[7:0];
            8'h0E:   read_data = pll_trim[15:8];
            8'h0F:   read_data = pll_trim[23:16];
            8'h10:   read_data = {6'b0, pll_trim[25:24]};
            8'h11:   read_data = {2'b0, pll90_sel, pll_sel};
            8'h12:   read_data = {3'b0, pll_div};
            default: read_data = 8'h00;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pll_ena     <= 1'b0;
            pll_dco_ena <= 1'b1;
            pll_bypass  <= 1'b1;
            pll_trim    <= 26'h3FFEFFF;
            pll_sel     <= 3'b010;
            pll90_sel   <= 3'b010;
            pll_div     <= 5'd4;
`ifdef HKSPI_IRQ_EN
            irq         <= 1'b0;
`endif
        end else if (write_strobe) begin
            case (addr)
                8'h08: {pll_dco_ena, pll_ena} <= byte_val[1:0];
                8'h09: pll_bypass             <= byte_val[0];
`ifdef HKSPI_IRQ_EN
                8'h0A: irq                    <= byte_val[0];
`endif
                8'h0D: pll_trim[7:0]          <= byte_val;
                8'h0E: pll_trim[15:8]         <= byte_val;
                8'h0F: pll_trim[23:16]        <= byte_val;
                8'h10: pll_trim[25:24]        <= byte_val[1:0];
                8'h11: {pll90_sel, pll_sel}   <= byte_val[5:0];
                8'h12: pll_div                <= byte_val[4:0];
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sysctrl_hkspi.sv
// Bit-bangs SPI frames at the housekeeping slave and compares read data and PLL pins
// against a byte-array register model.
module tb_sysctrl_hkspi;

    logic        clock = 1'b0;
    logic        reset;
    logic        pll_ena, pll_dco_ena, pll_bypass;
    logic [25:0] pll_trim;
    logic [2:0]  pll_sel, pll90_sel;
    logic [4:0]  pll_div;
`ifdef HKSPI_IRQ_EN
    logic        irq;
`endif

    always #5 clock = ~clock;

    sysctrl_hkspi_if hk();

    sysctrl_hkspi dut (
        .clock       (clock),
        .reset       (reset),
        .spi         (hk.slave),
`ifdef HKSPI_IRQ_EN
        .irq         (irq),
`endif
        .pll_ena     (pll_ena),
        .pll_dco_ena (pll_dco_ena),
        .pll_bypass  (pll_bypass),
        .pll_trim    (pll_trim),
        .pll_sel     (pll_sel),
        .pll90_sel   (pll90_sel),
        .pll_div     (pll_div)
    );

    int checkCount = 0;
    int passCount  = 0;

    logic [7:0] model_mem  [256];
    logic [7:0] model_mask [256];
    logic [7:0] tx_data [16];
    logic [7:0] rx_data [16];

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    endtask

    // Register model: every address is a byte; mask marks the writable bits
    task automatic modelReset();
        for (int i = 0; i < 256; i++) begin
            model_mem[i]  = 8'h00;
            model_mask[i] = 8'h00;
        end
        model_mem[8'h01] = 8'h04;
        model_mem[8'h02] = 8'h56;
        model_mem[8'h03] = 8'h10;
        model_mem[8'h08] = 8'h02; model_mask[8'h08] = 8'h03;
        model_mem[8'h09] = 8'h01; model_mask[8'h09] = 8'h01;
`ifdef HKSPI_IRQ_EN
        model_mask[8'h0A] = 8'h01;
`endif
        model_mem[8'h0D] = 8'hFF; model_mask[8'h0D] = 8'hFF;
        model_mem[8'h0E] = 8'hEF; model_mask[8'h0E] = 8'hFF;
        model_mem[8'h0F] = 8'hFF; model_mask[8'h0F] = 8'hFF;
        model_mem[8'h10] = 8'h03; model_mask[8'h10] = 8'h03;
        model_mem[8'h11] = 8'h12; model_mask[8'h11] = 8'h3F;
        model_mem[8'h12] = 8'h04; model_mask[8'h12] = 8'h1F;
    endtask

    task automatic checkPins();
        checkOutput("pll_ena",     {31'd0, pll_ena},     {31'd0, model_mem[8'h08][0]});
        checkOutput("pll_dco_ena", {31'd0, pll_dco_ena}, {31'd0, model_mem[8'h08][1]});
        checkOutput("pll_bypass",  {31'd0, pll_bypass},  {31'd0, model_mem[8'h09][0]});
        checkOutput("pll_trim",    {6'd0, pll_trim},
                    {6'd0, model_mem[8'h10][1:0], model_mem[8'h0F], model_mem[8'h0E], model_mem[8'h0D]});
        checkOutput("pll_sel",     {29'd0, pll_sel},     {29'd0, model_mem[8'h11][2:0]});
        checkOutput("pll90_sel",   {29'd0, pll90_sel},   {29'd0, model_mem[8'h11][5:3]});
        checkOutput("pll_div",     {27'd0, pll_div},     {27'd0, model_mem[8'h12][4:0]});
`ifdef HKSPI_IRQ_EN
        checkOutput("irq",         {31'd0, irq},         {31'd0, model_mem[8'h0A][0]});
`endif
        checkOutput("sdo_idle",    {31'd0, hk.sdo},      32'd0);
        checkOutput("sdo_oe_idle", {31'd0, hk.sdo_oe},   32'd0);
    endtask

    task automatic halfPeriod();
        repeat (4) @(negedge clock);
    endtask

    task automatic spiByte(input logic [7:0] tx, input int nbits, output logic [7:0] rx, output logic oe_seen);
        rx = 8'h00;
        oe_seen = 1'b0;
        for (int i = 7; i > 7 - nbits; i--) begin
            hk.sdi = tx[i];
            halfPeriod();
            rx[i]   = hk.sdo;
            oe_seen = oe_seen | hk.sdo_oe;
            hk.sck  = 1'b1;
            halfPeriod();
            hk.sck  = 1'b0;
        end
    endtask

    // One frame: command, address, nbytes of tx_data, then an optional partial byte
    task automatic applyStimulus(input logic [7:0] cmd, input logic [7:0] addr, input int nbytes, input int partial_bits);
        logic [7:0] rx;
        logic       oe, oe_any;
        logic [7:0] a;
        bit         valid;
        valid  = (cmd == 8'h80) || (cmd == 8'h40) || (cmd == 8'hC0);
        oe_any = 1'b0;
        hk.csb = 1'b0;
        halfPeriod();
        spiByte(cmd, 8, rx, oe);
        spiByte(addr, 8, rx, oe);
        for (int i = 0; i < nbytes; i++) begin
            spiByte(tx_data[i], 8, rx_data[i], oe);
            oe_any = oe_any | oe;
        end
        if (partial_bits > 0) spiByte(tx_data[nbytes], partial_bits, rx, oe);
        halfPeriod();
        hk.csb = 1'b1;
        repeat (8) @(negedge clock);
        if (valid) begin
            for (int i = 0; i < nbytes; i++) begin
                a = addr + 8'(i);
                if (cmd[6]) checkOutput($sformatf("rd@%02h", a), {24'd0, rx_data[i]}, {24'd0, model_mem[a]});
                if (cmd[7]) model_mem[a] = (model_mem[a] & ~model_mask[a]) | (tx_data[i] & model_mask[a]);
            end
        end
        if (nbytes > 0) checkOutput("sdo_oe_data", {31'd0, oe_any}, {31'd0, valid && cmd[6]});
        checkPins();
    endtask

    initial begin
        logic [7:0] rx, cmd, addr;
        logic       oe;
        int         n, part;

        reset  = 1'b1;
        hk.csb = 1'b1;
        hk.sck = 1'b0;
        hk.sdi = 1'b0;
        modelReset();
        repeat (5) @(negedge clock);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        checkPins();

        for (int i = 0; i < 16; i++) tx_data[i] = 8'h00;
        applyStimulus(8'h40, 8'h01, 3, 0);
        applyStimulus(8'h40, 8'h08, 11, 0);

        tx_data[0] = 8'h07;
        applyStimulus(8'h80, 8'h12, 1, 0);
        applyStimulus(8'h40, 8'h12, 1, 0);
        checkOutput("pll_div_7", {27'd0, pll_div}, 32'd7);
        tx_data[0] = 8'h02;
        applyStimulus(8'h80, 8'h01, 1, 0);
        applyStimulus(8'h40, 8'h01, 1, 0);

        tx_data[0] = 8'h00;
        applyStimulus(8'hC0, 8'h09, 1, 0);
        checkOutput("bypass_off", {31'd0, pll_bypass}, 32'd0);

        tx_data[0] = 8'h1A;
        applyStimulus(8'h80, 8'h12, 0, 4);
        checkOutput("abort_div", {27'd0, pll_div}, 32'd7);

        tx_data[0] = 8'h3F; tx_data[1] = 8'h05;
        applyStimulus(8'h80, 8'h11, 2, 0);
        hk.csb = 1'b0;
        halfPeriod();
        spiByte(8'h80, 8, rx, oe);
        spiByte(8'h0D, 8, rx, oe);
        spiByte(8'h55, 4, rx, oe);
        reset = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        hk.csb = 1'b1;
        repeat (8) @(negedge clock);
        modelReset();
        checkPins();
        applyStimulus(8'h40, 8'h08, 11, 0);

        applyStimulus(8'h40, 8'hFF, 2, 0);

        for (int t = 0; t < 40; t++) begin
            case ($urandom_range(0, 9))
                0, 1, 2: cmd = 8'h80;
                3, 4, 5: cmd = 8'h40;
                6, 7, 8: cmd = 8'hC0;
                default: cmd = 8'($urandom);
            endcase
            addr = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 8'h13));
            n    = $urandom_range(1, 4);
            part = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
            for (int i = 0; i < 16; i++) tx_data[i] = 8'($urandom);
            applyStimulus(cmd, addr, n, part);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
